posit_decode_arbiter: RTL
=========================

# posit_decode_arbiter

Shares a single posit decoder (`posit_denormalize`) among `NUM_REQ` requesters. Each requester uses an rts/rtr handshake. A round-robin arbiter grants one requester per cycle. The accepted word is captured, decoded and registered in a two-stage pipeline. The result leaves through an rts/rtr master port together with the originating requester index. The block sits between the posit operand sources and the arithmetic core.

## Interface
Parameters:
- `POSIT_WIDTH`, 16, posit word width.
- `POSIT_ES`, 0, exponent field width.
- `NUM_REQ`, 4, number of requesters, ≥2.

Derived widths:
- `SW` = `GET_SCALE_WIDTH(POSIT_WIDTH, POSIT_ES, 0)`.
- `FW` = `GET_FRACTION_WIDTH(POSIT_WIDTH, POSIT_ES, 0)`.
- `IW` = `$clog2(NUM_REQ)`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_rts_i`  in  NUM_REQ  per-requester word valid.
- `req_rtr_o`  out  NUM_REQ  per-requester grant/accept; at most one bit high.
- `req_posit_i`  in  NUM_REQ*POSIT_WIDTH  requester k occupies bits [k*POSIT_WIDTH +: POSIT_WIDTH].
- `rts_o`  out  1  decoded result valid.
- `rtr_i`  in  1  downstream ready.
- `id_o`  out  IW  index of the requester that supplied the result.
- `sign_o`  out  1  decoded sign.
- `inf_o`  out  1  NaR flag.
- `zero_o`  out  1  zero flag.
- `scale_o`  out  SW  decoded scale.
- `fraction_o`  out  FW  decoded fraction.

## Operation
Handshake rules:
- A transfer occurs when rts and rtr are both high on a rising edge.
- Requesters hold `req_rts_i` and their word stable until granted.
- The block never drops `rts_o` or changes its payload until `rtr_i` is seen.

Arbitration:
- Round-robin pointer `ptr` (IW bits) gives priority to requesters ptr, ptr+1, … mod NUM_REQ.
- The grant is combinational from `req_rts_i` and `ptr`.
- `req_rtr_o[k]` is high only for the highest-priority active requester, and only when stage A can accept.
- After a transfer from requester k, `ptr` becomes (k+1) mod NUM_REQ. With no transfer, `ptr` holds.

Pipeline:
- **Stage A** (register): `a_valid`, `a_posit`, `a_id`. Loads the granted word and index.
- **Decode**: `posit_denormalize` is instantiated once and fed from `a_posit`. It is purely combinational.
- **Stage B** (output register): `b_valid` (drives `rts_o`), `id_o`, and the decoded fields.

Flow control:
- B can load when `!b_valid || rtr_i`.
- A advances into B when `a_valid` and B can load.
- A can accept when `!a_valid` or A advances this cycle. A new grant and an A→B move may happen in the same cycle.
- If A advances and no grant occurs, `a_valid` clears. If B is accepted and A is empty, `b_valid` clears.
- Full throughput is one word per cycle with `rtr_i` held high.

Reset (asynchronous, `rst_n` low):
- `ptr`=0, `a_valid`=0, `b_valid`=0.
- All output payload (id, sign, inf, zero, scale, fraction) = 0.
- `req_rtr_o`=0 while in reset.
- Reset mid-operation discards in-flight words; requesters must re-present them.

## Timing
- Latency: a word accepted at edge N appears on `rts_o` after edge N+1 (two-register pipeline).
- Backpressure: with `rtr_i` low, B holds and A fills. The grant is suppressed from the next cycle until B drains.
- Fairness: a continuously requesting source waits at most NUM_REQ−1 transfers.
- Outputs are registered; only `req_rtr_o` is combinational (from `req_rts_i`, `ptr`, `a_valid`, `b_valid`, `rtr_i`).

## Test plan
- Reset, then single request: requester 2 presents 0x4000 (1.0, 16/0) with `rtr_i`=1. Required: `rts_o` two edges later with `id_o`=2, sign=0, scale=0, fraction=0, zero=0, inf=0; next `ptr`=3.
- Special values, requester 0: 0x0000 → zero=1. 0x8000 → inf=1. 0xC000 → sign=1, scale=0. 0x6000 → scale=1. 0x5000 → scale=0, fraction MSB=1.
- All four request continuously with `rtr_i`=1. Required: one grant per cycle in order 0,1,2,3,0,…; outputs stream with no gaps; `id_o` matches each source's word.
- Backpressure: `rtr_i`=0 for 5 cycles with all requesting. Required: exactly two words accepted, then all `req_rtr_o`=0. `rts_o` and the payload stay stable. After `rtr_i`=1, order and values are preserved with no loss or duplication.
- Sparse and skip: only requesters 1 and 3 active, `ptr`=2. Required: order 3,1,3,1; `ptr` wraps 3→0 correctly.
- Mid-stream reset: assert `rst_n`=0 with both stages full. Required: `rts_o`, `req_rtr_o` and the payload go to 0 immediately. After release, the first grant goes to requester 0 when active.

Source files
------------

// File: rtl/posit_decode_arbiter.sv
// Shared posit decoder with a round-robin front end.
// Several requesters compete for one posit_denormalize instance. The accepted
// word goes through a capture register (stage A) and the decoded fields land
// in an output register (stage B). The result leaves through an rts/rtr port
// tagged with the index of the requester that supplied it.

// Combinational posit field extractor.
// Zero and NaR are flagged, and all other fields read as zero for them.
// For ordinary values the sign is split off and the two's-complement magnitude
// is decoded. The regime run gives k, and scale = k*2^ES + exponent. The
// fraction is left-aligned without the hidden bit.
module posit_denormalize #(
  parameter int N  = 16,
  parameter int ES = 0,
  parameter int SW = 5,
  parameter int FW = 13
) (
  input  logic [N-1:0]  posit,
  output logic          sign,
  output logic          inf,
  output logic          zero,
  output logic [SW-1:0] scale,
  output logic [FW-1:0] fraction
);
  localparam int CW = $clog2(N);

  logic [N-2:0]  body;
  logic          rbit;
  logic          stop;
  logic [CW-1:0] run;
  logic [N-4:0]  rest;
  logic [SW-1:0] regime;
  logic [SW-1:0] expo;
  logic          special;

  // Magnitude below the sign bit, regime run length, and the bits after the terminator
  always_comb begin
    body = posit[N-1] ? (~posit[N-2:0] + {{(N-2){1'b0}}, 1'b1}) : posit[N-2:0];
    rbit = body[N-2];
    run  = '0;
    stop = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!stop) begin
        if (body[i] == rbit) run = run + CW'(1);
        else                 stop = 1'b1;
      end
    end
    // The regime occupies run bits plus one terminator. Shifting the remaining
    // N-3 low bits left by run-1 discards the rest of the regime in one step.
    rest   = body[N-4:0] << (run - CW'(1));
    regime = rbit ? (SW'(run) - SW'(1)) : (SW'(0) - SW'(run));
  end

  if (ES > 0) begin : g_exp
    assign expo = SW'(rest[N-4 -: ES]);
  end else begin : g_noexp
    assign expo = '0;
  end

  // Special-value detection, and final field selection
  always_comb begin
    special  = ~|posit[N-2:0];
    zero     = special & ~posit[N-1];
    inf      = special &  posit[N-1];
    sign     = special ? 1'b0 : posit[N-1];
    scale    = special ? '0 : ((regime << ES) + expo);
    fraction = special ? '0 : rest[FW-1:0];
  end
endmodule

// SW and FW are the closed forms of GET_SCALE_WIDTH and GET_FRACTION_WIDTH
// when no extra guard bits are requested.
module posit_decode_arbiter #(
  parameter  int POSIT_WIDTH = 16,
  parameter  int POSIT_ES    = 0,
  parameter  int NUM_REQ     = 4,
  localparam int SW          = $clog2(POSIT_WIDTH) + POSIT_ES + 1,
  localparam int FW          = POSIT_WIDTH - POSIT_ES - 3,
  localparam int IW          = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_rts_i,
  output logic [NUM_REQ-1:0]             req_rtr_o,
  input  logic [NUM_REQ*POSIT_WIDTH-1:0] req_posit_i,
  output logic                           rts_o,
  input  logic                           rtr_i,
  output logic [IW-1:0]                  id_o,
  output logic                           sign_o,
  output logic                           inf_o,
  output logic                           zero_o,
  output logic [SW-1:0]                  scale_o,
  output logic [FW-1:0]                  fraction_o
);
  logic [IW-1:0]          ptr;
  logic [NUM_REQ-1:0]     grant;
  logic [IW-1:0]          grant_id;
  logic [IW-1:0]          idx;
  logic                   found;
  logic [POSIT_WIDTH-1:0] grant_word;

  logic                   a_valid;
  logic [POSIT_WIDTH-1:0] a_posit;
  logic [IW-1:0]          a_id;
  logic                   b_valid;

  logic                   b_load;
  logic                   a_adv;
  logic                   a_ready;
  logic                   take;

  logic                   dec_sign;
  logic                   dec_inf;
  logic                   dec_zero;
  logic [SW-1:0]          dec_scale;
  logic [FW-1:0]          dec_fraction;

  // Round-robin search: the first active requester at or after ptr wins
  always_comb begin
    grant    = '0;
    grant_id = '0;
    idx      = '0;
    found    = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = IW'((int'(ptr) + off) % NUM_REQ);
      if (!found && req_rts_i[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
  end

  assign b_load     = !b_valid || rtr_i;
  assign a_adv      = a_valid && b_load;
  assign a_ready    = !a_valid || a_adv;
  assign req_rtr_o  = (rst_n && a_ready) ? grant : '0;
  assign take       = |req_rtr_o;
  assign grant_word = req_posit_i[grant_id*POSIT_WIDTH +: POSIT_WIDTH];
  assign rts_o      = b_valid;

  // After a transfer, the requester just served drops to lowest priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (take) begin
      ptr <= (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + IW'(1);
    end
  end

  // Stage A captures the granted word. It empties only when it advances and nothing new arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid <= 1'b0;
      a_posit <= '0;
      a_id    <= '0;
    end else if (take) begin
      a_valid <= 1'b1;
      a_posit <= grant_word;
      a_id    <= grant_id;
    end else if (a_adv) begin
      a_valid <= 1'b0;
    end
  end

  posit_denormalize #(
    .N  (POSIT_WIDTH),
    .ES (POSIT_ES),
    .SW (SW),
    .FW (FW)
  ) u_dec (
    .posit    (a_posit),
    .sign     (dec_sign),
    .inf      (dec_inf),
    .zero     (dec_zero),
    .scale    (dec_scale),
    .fraction (dec_fraction)
  );

  // Stage B: the payload stays frozen while the result waits for rtr_i
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_valid    <= 1'b0;
      id_o       <= '0;
      sign_o     <= 1'b0;
      inf_o      <= 1'b0;
      zero_o     <= 1'b0;
      scale_o    <= '0;
      fraction_o <= '0;
    end else if (b_load) begin
      b_valid <= a_valid;
      if (a_valid) begin
        id_o       <= a_id;
        sign_o     <= dec_sign;
        inf_o      <= dec_inf;
        zero_o     <= dec_zero;
        scale_o    <= dec_scale;
        fraction_o <= dec_fraction;
      end
    end
  end
endmodule
